// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_pkg
// Description : Shared constants for the PS/2 keyboard front end. Holds the
//               scan-code prefixes, special codes, the default tracked keys
//               and the state encodings of the receive and decode FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package keyboard_pkg;

    // Prefix and special scan codes
    localparam logic [7:0] SC_EXT    = 8'hE0;   // extended-key prefix
    localparam logic [7:0] SC_BREAK  = 8'hF0;   // key-release prefix
    localparam logic [7:0] SC_PAUSE  = 8'hE1;   // Pause/Break sequence start
    localparam logic [7:0] SC_BAT    = 8'hAA;   // self-test passed
    localparam logic [7:0] SC_OVR_LO = 8'h00;   // buffer overrun (set 2)
    localparam logic [7:0] SC_OVR_HI = 8'hFF;   // buffer overrun (set 1)

    // Number of bytes that follow E1 in the Pause make sequence
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    // Tracked keys as {ext, code}
    localparam logic [8:0] KEY_UP   = 9'h175;
    localparam logic [8:0] KEY_DOWN = 9'h172;
    localparam logic [8:0] KEY_W    = 9'h01D;
    localparam logic [8:0] KEY_S    = 9'h01B;

    // PS/2 frame receive states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Scan-code decode states
    typedef enum logic [0:0] {
        DEC_IDLE = 1'b0,
        DEC_SKIP = 1'b1
    } dec_state_t;

endpackage
`default_nettype wire

// File: rtl/keyboard_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_ps2_rx
// Description : PS/2 byte receiver running entirely on the system clock.
//               Synchronises and glitch-filters kclk/kdata, samples data on
//               filtered kclk falling edges and checks start/parity/stop and
//               the inter-edge timeout.
// Ports       : clk, rst_n   - system clock, async active-low reset
//               kclk, kdata  - raw PS/2 lines (asynchronous)
//               rx_byte      - last received data byte (stable after valid)
//               byte_valid   - 1-cycle pulse, cycle after the stop-bit edge
//               err          - 1-cycle pulse on parity/stop/timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_ps2_rx
    import keyboard_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TIMER_W     = $clog2(TIMEOUT_CYC + 1);

    // ------------------------------------------------------------------
    // Synchronisers: bit 0 = kclk, bit 1 = kdata. Preset to the idle-high
    // bus level so reset release never looks like a falling edge.
    // ------------------------------------------------------------------
    logic [1:0] sync_a;
    logic [1:0] sync_b;
    logic [1:0] filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= {kdata, kclk};
            sync_b <= sync_a;
        end
    end

    // Glitch filters: output follows the input only after FILTER_LEN
    // consecutive samples that differ from the current output.
    for (genvar i = 0; i < 2; i++) begin : g_filter
        logic [7:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt     <= 8'd0;
                filt[i] <= 1'b1;
            end else if (sync_b[i] == filt[i]) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(FILTER_LEN - 1)) begin
                cnt     <= 8'd0;
                filt[i] <= sync_b[i];
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    logic kclk_f;
    logic kdata_f;
    logic kclk_prev;
    logic fall;

    assign kclk_f  = filt[0];
    assign kdata_f = filt[1];
    assign fall    = kclk_prev & ~kclk_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) kclk_prev <= 1'b1;
        else        kclk_prev <= kclk_f;
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t        state;
    rx_state_t        state_next;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             parity_ok;
    logic [TIMER_W-1:0] timer;
    logic             timeout;
    logic             valid_next;
    logic             err_next;

    // A timeout fires TIMEOUT_CYC cycles after the last falling edge; an
    // edge arriving on that very cycle wins and the frame continues.
    assign timeout = (state != RX_IDLE) && !fall &&
                     (timer == TIMER_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            RX_IDLE: begin
                // A high "start bit" is ignored: the line simply stays idle.
                if (fall && !kdata_f) state_next = RX_DATA;
            end
            RX_DATA: begin
                if (fall && (bit_cnt == 3'd7)) state_next = RX_PARITY;
            end
            RX_PARITY: begin
                if (fall) state_next = RX_STOP;
            end
            RX_STOP: begin
                if (fall) begin
                    state_next = RX_IDLE;
                    if (kdata_f && parity_ok) valid_next = 1'b1;
                    else                      err_next   = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
        // Timeout overrides everything; shares the single err pulse.
        if (timeout) begin
            state_next = RX_IDLE;
            valid_next = 1'b0;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= 8'd0;
            bit_cnt    <= 3'd0;
            parity_ok  <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_valid <= valid_next;
            err        <= err_next;

            if ((state == RX_IDLE) || fall) timer <= '0;
            else                            timer <= timer + 1'b1;

            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= 3'd0;
                    RX_DATA: begin
                        shift   <= {kdata_f, shift[7:1]};   // LSB first
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    RX_PARITY: parity_ok <= ^{shift, kdata_f};
                    default:   ;
                endcase
            end
        end
    end

    assign rx_byte = shift;

endmodule
`default_nettype wire

// File: rtl/keyboard_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_scanner
// Description : PS/2 keyboard front end. Receives scan-code bytes, decodes
//               E0/F0/E1 prefixes, emits one event per scan code and keeps a
//               held-key bitmap for the keys listed in KEY_CODES.
// Ports       : keyboard_clk, keyboard_rst_n - clock, async active-low reset
//               keyboard_kclk, keyboard_kdata - raw PS/2 lines
//               keyboard_out       - held-key bitmap (1 = pressed)
//               keyboard_evt_valid - 1-cycle event pulse
//               keyboard_evt_code/ext/break - event contents (held)
//               keyboard_err       - 1-cycle receive error pulse
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_scanner
    import keyboard_pkg::*;
#(
    parameter int                    CLK_HZ     = 100_000_000,
    parameter int                    NUM_KEYS   = 4,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES  = {KEY_S, KEY_W, KEY_DOWN, KEY_UP},
    parameter int                    FILTER_LEN = 8,
    parameter int                    TIMEOUT_US = 2000
) (
    input  logic                keyboard_clk,
    input  logic                keyboard_rst_n,
    input  logic                keyboard_kclk,
    input  logic                keyboard_kdata,
    output logic [NUM_KEYS-1:0] keyboard_out,
    output logic                keyboard_evt_valid,
    output logic [7:0]          keyboard_evt_code,
    output logic                keyboard_evt_ext,
    output logic                keyboard_evt_break,
    output logic                keyboard_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;

    keyboard_ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk        (keyboard_clk),
        .rst_n      (keyboard_rst_n),
        .kclk       (keyboard_kclk),
        .kdata      (keyboard_kdata),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .err        (keyboard_err)
    );

    // ------------------------------------------------------------------
    // Decode FSM
    // ------------------------------------------------------------------
    dec_state_t dec_state;
    dec_state_t dec_next;
    logic       ext_flag;
    logic       brk_flag;
    logic [2:0] skip_cnt;

    logic set_ext;
    logic set_brk;
    logic clear_flags;
    logic clear_keys;
    logic start_skip;
    logic skip_dec;
    logic fire;

    always_ff @(posedge keyboard_clk or negedge keyboard_rst_n) begin
        if (!keyboard_rst_n) dec_state <= DEC_IDLE;
        else                 dec_state <= dec_next;
    end

    always_comb begin
        dec_next    = dec_state;
        set_ext     = 1'b0;
        set_brk     = 1'b0;
        clear_flags = 1'b0;
        clear_keys  = 1'b0;
        start_skip  = 1'b0;
        skip_dec    = 1'b0;
        fire        = 1'b0;
        if (byte_valid) begin
            case (dec_state)
                DEC_IDLE: begin
                    case (rx_byte)
                        SC_EXT:   set_ext = 1'b1;
                        SC_BREAK: set_brk = 1'b1;
                        SC_PAUSE: begin
                            start_skip  = 1'b1;
                            clear_flags = 1'b1;
                            dec_next    = DEC_SKIP;
                        end
                        // Keyboard restarted or overflowed: nothing is held.
                        SC_BAT, SC_OVR_LO, SC_OVR_HI: begin
                            clear_keys  = 1'b1;
                            clear_flags = 1'b1;
                        end
                        default: begin
                            fire        = 1'b1;
                            clear_flags = 1'b1;
                        end
                    endcase
                end
                DEC_SKIP: begin
                    // Remaining Pause bytes are swallowed without decoding.
                    skip_dec    = 1'b1;
                    clear_flags = 1'b1;
                    if (skip_cnt == 3'd1) dec_next = DEC_IDLE;
                end
                default: dec_next = DEC_IDLE;
            endcase
        end
    end

    always_ff @(posedge keyboard_clk or negedge keyboard_rst_n) begin
        if (!keyboard_rst_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            skip_cnt <= 3'd0;
        end else begin
            if (clear_flags) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else begin
                if (set_ext) ext_flag <= 1'b1;
                if (set_brk) brk_flag <= 1'b1;
            end
            if (start_skip)    skip_cnt <= PAUSE_TAIL;
            else if (skip_dec) skip_cnt <= skip_cnt - 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Event registers
    // ------------------------------------------------------------------
    always_ff @(posedge keyboard_clk or negedge keyboard_rst_n) begin
        if (!keyboard_rst_n) begin
            keyboard_evt_valid <= 1'b0;
            keyboard_evt_code  <= 8'd0;
            keyboard_evt_ext   <= 1'b0;
            keyboard_evt_break <= 1'b0;
        end else begin
            keyboard_evt_valid <= fire;
            if (fire) begin
                keyboard_evt_code  <= rx_byte;
                keyboard_evt_ext   <= ext_flag;
                keyboard_evt_break <= brk_flag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Held-key table: every matching entry updates, so duplicates track
    // the same key.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        localparam logic [8:0] CODE = KEY_CODES[9*i +: 9];
        logic held;

        always_ff @(posedge keyboard_clk or negedge keyboard_rst_n) begin
            if (!keyboard_rst_n) begin
                held <= 1'b0;
            end else if (clear_keys) begin
                held <= 1'b0;
            end else if (fire && (CODE == {ext_flag, rx_byte})) begin
                held <= ~brk_flag;
            end
        end

        assign keyboard_out[i] = held;
    end

endmodule
`default_nettype wire

// File: tb/tb_keyboard_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keyboard_scanner
// Description : Directed self-checking bench for keyboard_scanner. Drives
//               PS/2 frames bit by bit (with 1 ns kclk glitches) and checks
//               the key bitmap, event stream and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keyboard_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kclk = 1'b1;
    logic       kdata = 1'b1;
    logic [3:0] key_out;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    int         evt_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] last_code = 8'd0;
    logic       last_ext = 1'b0;
    logic       last_brk = 1'b0;

    int e0;
    int r0;

    // 1 MHz nominal with 400 us timeout -> 400-cycle timeout budget
    keyboard_scanner #(
        .CLK_HZ     (1_000_000),
        .NUM_KEYS   (4),
        .KEY_CODES  ({9'h01B, 9'h01D, 9'h172, 9'h175}),
        .FILTER_LEN (4),
        .TIMEOUT_US (400)
    ) dut (
        .keyboard_clk       (clk),
        .keyboard_rst_n     (rst_n),
        .keyboard_kclk      (kclk),
        .keyboard_kdata     (kdata),
        .keyboard_out       (key_out),
        .keyboard_evt_valid (evt_valid),
        .keyboard_evt_code  (evt_code),
        .keyboard_evt_ext   (evt_ext),
        .keyboard_evt_break (evt_break),
        .keyboard_err       (err)
    );

    always #5 clk = ~clk;

    // Event / error monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (evt_valid) begin
            evt_cnt   <= evt_cnt + 1;
            last_code <= evt_code;
            last_ext  <= evt_ext;
            last_brk  <= evt_break;
        end
        if (err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One PS/2 bit: data set while kclk high (with a 1 ns glitch), then a
    // long low phase during which the device's data is sampled.
    task automatic ps2_bit(input logic b);
        kdata = b;
        wait_clks(5);
        kclk = 1'b0;
        #1;
        kclk = 1'b1;
        wait_clks(5);
        kclk = 1'b0;
        wait_clks(20);
        kclk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(1'b1);
        kdata = 1'b1;
        wait_clks(20);
    endtask

    task automatic mark;
        e0 = evt_cnt;
        r0 = err_cnt;
    endtask

    initial begin
        // Reset state
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(2);
        chk("reset_out",   32'(key_out),   32'h0);
        chk("reset_valid", 32'(evt_valid), 32'h0);
        chk("reset_err",   32'(err),       32'h0);
        chk("reset_code",  32'(evt_code),  32'h0);

        // Abandon a frame with a reset; the next frame must decode cleanly
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        kdata = 1'b1;
        rst_n = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(10);
        chk("midreset_out", 32'(key_out), 32'h0);

        // Make W
        mark();
        send_byte(8'h1D, 1'b0);
        chk("w_make_evts", 32'(evt_cnt - e0), 32'd1);
        chk("w_make_code", 32'(last_code),    32'h1D);
        chk("w_make_ext",  32'(last_ext),     32'h0);
        chk("w_make_brk",  32'(last_brk),     32'h0);
        chk("w_make_out",  32'(key_out),      32'b0100);

        // Break W
        mark();
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        chk("w_brk_evts", 32'(evt_cnt - e0), 32'd1);
        chk("w_brk_brk",  32'(last_brk),     32'h1);
        chk("w_brk_out",  32'(key_out),      32'b0000);

        // Extended arrows
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("up_out", 32'(key_out),  32'b0001);
        chk("up_ext", 32'(last_ext), 32'h1);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h72, 1'b0);
        chk("down_out", 32'(key_out),  32'b0011);
        chk("down_ext", 32'(last_ext), 32'h1);
        mark();
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("up_brk_out",  32'(key_out),      32'b0010);
        chk("up_brk_ext",  32'(last_ext),     32'h1);
        chk("up_brk_brk",  32'(last_brk),     32'h1);
        chk("up_brk_evts", 32'(evt_cnt - e0), 32'd1);

        // Bad parity, then the same byte good
        mark();
        send_byte(8'h1B, 1'b1);
        chk("par_err",  32'(err_cnt - r0), 32'd1);
        chk("par_evts", 32'(evt_cnt - e0), 32'd0);
        chk("par_out",  32'(key_out),      32'b0010);
        send_byte(8'h1B, 1'b0);
        chk("s_make_out", 32'(key_out), 32'b1010);

        // Timeout after 5 data bits
        mark();
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        kdata = 1'b1;
        wait_clks(500);
        chk("tmo_err",  32'(err_cnt - r0), 32'd1);
        chk("tmo_evts", 32'(evt_cnt - e0), 32'd0);
        send_byte(8'h1D, 1'b0);
        chk("tmo_next_code", 32'(last_code), 32'h1D);
        chk("tmo_next_out",  32'(key_out),   32'b1110);

        // Typematic repeat of W
        mark();
        for (int i = 0; i < 10; i++) send_byte(8'h1D, 1'b0);
        chk("rep_evts", 32'(evt_cnt - e0), 32'd10);
        chk("rep_out",  32'(key_out),      32'b1110);

        // Self-test code clears everything
        mark();
        send_byte(8'hAA, 1'b0);
        chk("bat_out",  32'(key_out),      32'b0000);
        chk("bat_evts", 32'(evt_cnt - e0), 32'd0);

        // Pause sequence swallows 7 bytes
        mark();
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1D, 1'b0);
        chk("pause_evts", 32'(evt_cnt - e0), 32'd0);
        chk("pause_out",  32'(key_out),      32'b0000);
        send_byte(8'h1B, 1'b0);
        chk("pause_next_evts", 32'(evt_cnt - e0), 32'd1);
        chk("pause_next_code", 32'(last_code),    32'h1B);
        chk("pause_next_ext",  32'(last_ext),     32'h0);
        chk("pause_next_out",  32'(key_out),      32'b1000);

        // Break of a key that is not held
        mark();
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("nohold_brk_evts", 32'(evt_cnt - e0), 32'd1);
        chk("nohold_brk_out",  32'(key_out),      32'b1000);

        // Exactly the two intended errors over the whole run
        chk("total_errs", 32'(err_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
